// File: rtl/pulse_train_meter.sv
// pulse_train_meter
// Receive-side meter for a selectable-rate pulse train. Synchronises the
// asynchronous input, measures rise-to-rise period and high time in clk
// cycles, classifies the period into one of three rate modes, tracks lock
// on a stable classification and flags loss of signal.
module pulse_train_meter #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000,
   parameter int TOL     = 2,
   parameter int LOCK_N  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic [1:0]       mode_out,
   output logic             mode_locked,
   output logic             timeout
);

   // Match counter only needs to reach LOCK_N, where it saturates.
   localparam int MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

   // Classification runs one bit wider than the counter so that the
   // window edges (cnt + TOL, centre + TOL) can never wrap.
   localparam logic [CNT_W:0] TOL_X  = (CNT_W+1)'(TOL);
   localparam logic [CNT_W:0] C32_X  = (CNT_W+1)'(32);
   localparam logic [CNT_W:0] C64_X  = (CNT_W+1)'(64);
   localparam logic [CNT_W:0] C128_X = (CNT_W+1)'(128);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_N);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   state_t           state;
   logic             s1, s2, s3;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;
   logic [MW-1:0]    match_cnt;
   logic [1:0]       cls_next;
   logic [MW-1:0]    match_next;

   // True when x lies within +/- TOL of centre, without any subtraction.
   function automatic logic near(input logic [CNT_W:0] x, input logic [CNT_W:0] centre);
      return ((x + TOL_X) >= centre) && (x <= (centre + TOL_X));
   endfunction

   assign rise = s2 & ~s3;

   // Three-flop synchroniser; s3 is only kept to detect the rising edge on s2.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= pulse_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Classify the running count and work out the lock counter it would produce.
   always_comb begin
      cls_next   = 2'b11;
      match_next = '0;
      if (near({1'b0, cnt}, C32_X))
         cls_next = 2'b00;
      else if (near({1'b0, cnt}, C64_X))
         cls_next = 2'b01;
      else if (near({1'b0, cnt}, C128_X))
         cls_next = 2'b10;
      if (cls_next == 2'b11)
         match_next = '0;
      else if (cls_next == mode_out)
         match_next = (match_cnt >= LOCK_C) ? match_cnt : match_cnt + MW'(1);
      else
         match_next = MW'(1);
   end

   // Measurement FSM with registered results and strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         hcnt        <= '0;
         match_cnt   <= '0;
         period      <= '0;
         high_time   <= '0;
         mode_out    <= 2'b11;
         meas_valid  <= 1'b0;
         mode_locked <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         timeout    <= 1'b0;
         if (!en) begin
            // Disabling drops lock and the partial count but keeps the last result.
            state       <= IDLE;
            cnt         <= '0;
            hcnt        <= '0;
            match_cnt   <= '0;
            mode_locked <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= ARM;
               ARM: begin
                  if (rise) begin
                     cnt       <= CNT_W'(1);
                     hcnt      <= CNT_W'(1);
                     match_cnt <= '0;
                     state     <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (rise) begin
                     // A rise on the timeout cycle still counts as a measurement.
                     period      <= cnt;
                     high_time   <= hcnt;
                     mode_out    <= cls_next;
                     match_cnt   <= match_next;
                     mode_locked <= (match_next >= LOCK_C);
                     meas_valid  <= 1'b1;
                     cnt         <= CNT_W'(1);
                     hcnt        <= CNT_W'(1);
                  end else if (cnt == TIMEOUT_C) begin
                     timeout     <= 1'b1;
                     mode_locked <= 1'b0;
                     match_cnt   <= '0;
                     cnt         <= '0;
                     hcnt        <= '0;
                     state       <= ARM;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                     if (s2)
                        hcnt <= hcnt + CNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pulse_train_meter.sv
// Scoreboard bench for pulse_train_meter: each driven rise that closes a
// period pushes the expected measurement; a monitor pops it on meas_valid.
module tb_pulse_train_meter;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 1000;
   localparam int TOL     = 2;
   localparam int LOCK_N  = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             pulse_in = 1'b0;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic [1:0]       mode_out;
   logic             mode_locked;
   logic             timeout;

   typedef struct {
      int       p;
      int       h;
      logic [1:0] mode;
      logic     locked;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   bit   measuring = 0;
   int   last_p = 0;
   int   last_h = 0;
   int   exp_prev = 3;
   int   exp_match = 0;
   bit   to_allowed = 0;

   pulse_train_meter #(
      .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL), .LOCK_N(LOCK_N)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
      .period(period), .high_time(high_time), .meas_valid(meas_valid),
      .mode_out(mode_out), .mode_locked(mode_locked), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic int classify(input int p);
      int d32, d64, d128;
      d32  = (p > 32)  ? p - 32  : 32 - p;
      d64  = (p > 64)  ? p - 64  : 64 - p;
      d128 = (p > 128) ? p - 128 : 128 - p;
      if (d32 <= TOL) return 0;
      if (d64 <= TOL) return 1;
      if (d128 <= TOL) return 2;
      return 3;
   endfunction

   // Called at the cycle a rise is driven: predicts the result for the period it closes.
   task automatic note_rise(input int p, input int h);
      exp_t e;
      int c;
      if (measuring) begin
         c = classify(last_p);
         if (c == 3) exp_match = 0;
         else if (c == exp_prev) exp_match = (exp_match >= LOCK_N) ? LOCK_N : exp_match + 1;
         else exp_match = 1;
         exp_prev = c;
         e.p = last_p;
         e.h = last_h;
         e.mode = 2'(c);
         e.locked = (exp_match >= LOCK_N);
         exp_q.push_back(e);
      end else begin
         measuring = 1;
      end
      last_p = p;
      last_h = h;
   endtask

   task automatic drive_period(input int p, input int h);
      for (int i = 0; i < p; i++) begin
         @(negedge clk);
         if (i == 0) note_rise(p, h);
         pulse_in = (i < h);
      end
   endtask

   // Monitor: pops the scoreboard on every measurement strobe.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (meas_valid && timeout) begin
            total++; bad++;
            $display("FAIL strobe_overlap meas_valid=1 timeout=1 required never both");
         end
         if (timeout && !to_allowed) begin
            total++; bad++;
            $display("FAIL unexpected_timeout got=1 required=0");
         end
         if (meas_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_meas period=%0d required no measurement", period);
            end else begin
               e = exp_q.pop_front();
               total += 4;
               if (period !== CNT_W'(e.p)) begin
                  bad++; $display("FAIL meas_period got=%0d required=%0d", period, e.p);
               end
               if (high_time !== CNT_W'(e.h)) begin
                  bad++; $display("FAIL meas_high got=%0d required=%0d (period %0d)", high_time, e.h, e.p);
               end
               if (mode_out !== e.mode) begin
                  bad++; $display("FAIL meas_mode got=%b required=%b (period %0d)", mode_out, e.mode, e.p);
               end
               if (mode_locked !== e.locked) begin
                  bad++; $display("FAIL meas_locked got=%b required=%b (period %0d)", mode_locked, e.locked, e.p);
               end
               $display("meas period=%0d high=%0d mode=%b locked=%b", period, high_time, mode_out, mode_locked);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; pulse_in = 1'b0;
      repeat (3) @(negedge clk);
      total += 6;
      if (period !== '0)        begin bad++; $display("FAIL rst_period got=%0d required=0", period); end
      if (high_time !== '0)     begin bad++; $display("FAIL rst_high got=%0d required=0", high_time); end
      if (mode_out !== 2'b11)   begin bad++; $display("FAIL rst_mode got=%b required=11", mode_out); end
      if (meas_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid got=%b required=0", meas_valid); end
      if (mode_locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b required=0", mode_locked); end
      if (timeout !== 1'b0)     begin bad++; $display("FAIL rst_timeout got=%b required=0", timeout); end
      $display("reset check done");
      rst = 1'b0; en = 1'b1;
      measuring = 0; exp_prev = 3; exp_match = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_mode00();
      repeat (5) drive_period(32, 16);
   endtask

   task automatic test_rate_change();
      repeat (4) drive_period(64, 32);
      repeat (3) drive_period(128, 64);
   endtask

   task automatic test_tolerance();
      drive_period(30, 15);
      drive_period(34, 17);
      drive_period(30, 15);
      drive_period(29, 14);
      drive_period(35, 17);
      drive_period(66, 33);
   endtask

   task automatic test_duty();
      repeat (2) drive_period(64, 10);
   endtask

   task automatic test_timeout();
      int mv_c, to_c;
      repeat (4) drive_period(32, 16);
      mv_c = -1; to_c = -1;
      to_allowed = 1;
      @(negedge clk);
      note_rise(32, 16);
      pulse_in = 1'b1;
      for (int c = 1; c <= 1100 && to_c < 0; c++) begin
         @(negedge clk);
         if (c == 16) pulse_in = 1'b0;
         if (meas_valid && mv_c < 0) mv_c = c;
         if (timeout) begin
            to_c = c;
            total += 3;
            if (mode_locked !== 1'b0) begin bad++; $display("FAIL to_locked got=%b required=0", mode_locked); end
            if (mode_out !== 2'b00)   begin bad++; $display("FAIL to_mode_hold got=%b required=00", mode_out); end
            if (period !== CNT_W'(32)) begin bad++; $display("FAIL to_period_hold got=%0d required=32", period); end
         end
      end
      total++;
      if (to_c < 0 || mv_c < 0) begin
         bad++; $display("FAIL to_seen meas_cycle=%0d timeout_cycle=%0d required both within budget", mv_c, to_c);
      end else if (to_c - mv_c != TIMEOUT) begin
         bad++; $display("FAIL to_delay got=%0d required=%0d cycles after meas_valid", to_c - mv_c, TIMEOUT);
      end
      $display("timeout meas_cycle=%0d timeout_cycle=%0d", mv_c, to_c);
      @(negedge clk);
      total++;
      if (timeout !== 1'b0) begin bad++; $display("FAIL to_single got=%b required=0", timeout); end
      to_allowed = 0;
      measuring = 0; exp_match = 0;
      repeat (2) drive_period(32, 16);
   endtask

   task automatic test_reset_mid();
      repeat (3) drive_period(32, 16);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (i == 0) note_rise(32, 16);
         pulse_in = (i < 16);
         if (i == 10) begin
            rst = 1'b1;
            measuring = 0; exp_prev = 3; exp_match = 0;
         end
         if (i == 13) begin
            total += 4;
            if (period !== '0)        begin bad++; $display("FAIL mid_rst_period got=%0d required=0", period); end
            if (high_time !== '0)     begin bad++; $display("FAIL mid_rst_high got=%0d required=0", high_time); end
            if (mode_out !== 2'b11)   begin bad++; $display("FAIL mid_rst_mode got=%b required=11", mode_out); end
            if (mode_locked !== 1'b0) begin bad++; $display("FAIL mid_rst_locked got=%b required=0", mode_locked); end
            $display("mid-period reset check done");
         end
         if (i == 20) rst = 1'b0;
      end
      repeat (2) drive_period(32, 16);
   endtask

   task automatic test_enable_mid();
      repeat (3) drive_period(32, 16);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (i == 0) note_rise(32, 16);
         pulse_in = (i < 16);
         if (i == 9) begin
            total++;
            if (mode_locked !== 1'b1) begin bad++; $display("FAIL en_pre_locked got=%b required=1", mode_locked); end
         end
         if (i == 10) begin
            en = 1'b0;
            measuring = 0; exp_match = 0;
         end
         if (i == 13) begin
            total += 4;
            if (period !== CNT_W'(32)) begin bad++; $display("FAIL en_period_hold got=%0d required=32", period); end
            if (high_time !== CNT_W'(16)) begin bad++; $display("FAIL en_high_hold got=%0d required=16", high_time); end
            if (mode_out !== 2'b00)    begin bad++; $display("FAIL en_mode_hold got=%b required=00", mode_out); end
            if (mode_locked !== 1'b0)  begin bad++; $display("FAIL en_locked got=%b required=0", mode_locked); end
            $display("enable-off hold check done");
         end
         if (i == 15) en = 1'b1;
      end
      repeat (2) drive_period(32, 16);
   endtask

   task automatic test_drain();
      @(negedge clk);
      note_rise(32, 16);
      pulse_in = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL drain outstanding=%0d required=0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_mode00();
      test_rate_change();
      test_tolerance();
      test_duty();
      test_timeout();
      test_reset_mid();
      test_enable_mid();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time budget expired");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule

// File: doc/pulse_train_meter.md
# pulse_train_meter

Receive-side companion to the selectable-rate pulse generator. Samples an asynchronous pulse train, measures period and high time in `clk` cycles, and classifies each period into a rate mode. It reports lock once the classification is stable, and flags loss of signal. Used for loopback self-check of the generator output and for qualifying externally supplied pulse trains.

## Interface
- `CNT_W`, 16: width of period/high-time counters.
- `TIMEOUT`, 1000: cycles without a rising edge before loss of signal; must be < 2^CNT_W − 1.
- `TOL`, 2: ± tolerance in cycles for mode classification.
- `LOCK_N`, 3: consecutive identical valid classifications required for lock.

Reset: rst, synchronous, active-high; clock clk.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `en`  in  1  measurement enable; low forces IDLE.
- `pulse_in`  in  1  asynchronous pulse train.
- `period`  out  CNT_W  last measured rise-to-rise period, in cycles.
- `high_time`  out  CNT_W  cycles the input was high within that period.
- `meas_valid`  out  1  one-cycle strobe; `period`, `high_time` and `mode_out` updated together.
- `mode_out`  out  2  classification: 00 ≈ 32, 01 ≈ 64, 10 ≈ 128, 11 = unrecognised.
- `mode_locked`  out  1  stable classification held.
- `timeout`  out  1  one-cycle strobe on loss of signal.

## Operation
- **Synchronizer:** `pulse_in` feeds flops s1 → s2 → s3. Define `rise = s2 & ~s3`. High sampling uses s2.
- **FSM states:** IDLE, ARM, MEASURE.
  - IDLE → ARM when `en` = 1.
  - Any state → IDLE when `en` = 0. Counters clear; `mode_locked` clears; outputs hold their values.
  - ARM: wait for `rise`. On `rise`, set cnt = 1, hcnt = 1, match count = 0, and go to MEASURE. No measurement is reported from ARM.
- **MEASURE, each cycle without `rise`:**
  - cnt += 1.
  - hcnt += 1 if s2 = 1.
- **MEASURE, cycle with `rise`:**
  - Register `period` = cnt and `high_time` = hcnt.
  - Classify and pulse `meas_valid`.
  - Set cnt = 1, hcnt = 1.
- **Classification:**
  - |cnt − 32| ≤ TOL → 00.
  - |cnt − 64| ≤ TOL → 01.
  - |cnt − 128| ≤ TOL → 10.
  - Otherwise → 11.
  - Comparisons are unsigned, evaluated in CNT_W+1 bits, with no wrap.
- **Lock:**
  - If the new class equals the previous class and is not 11, match count increments, saturating at LOCK_N. Otherwise match count = 1 (0 if the class is 11).
  - `mode_locked` = (match count ≥ LOCK_N).
  - A differing class or a class of 11 drops lock in the same cycle that `meas_valid` asserts.
- **Timeout:**
  - In MEASURE, if cnt reaches TIMEOUT with no `rise`: pulse `timeout`, clear `mode_locked` and match count, go to ARM.
  - cnt never exceeds TIMEOUT and never wraps.
  - `rise` in the same cycle cnt = TIMEOUT: the measurement wins and no timeout is raised.
- **Reset values:** state IDLE, s1–s3 = 0, `period` = 0, `high_time` = 0, `mode_out` = 11, `meas_valid` = 0, `mode_locked` = 0, `timeout` = 0. Reset mid-measurement discards the partial count.

## Timing
- Input to detection: a `pulse_in` transition sampled at edge k appears on s2 at edge k+1. `rise` is valid during the cycle after k+1.
- Strobe latency: `meas_valid`, `period`, `high_time`, `mode_out` and `mode_locked` update at the first clk edge after `rise`. The latency from the input edge is therefore 3 clk edges.
- `timeout` is registered and asserts 1 cycle after cnt = TIMEOUT is reached.
- `meas_valid` and `timeout` are never high in the same cycle.
- Minimum measurable period is 2 cycles. Input pulses shorter than 1 cycle may be missed; no glitch filtering is done.
- `en` deasserted takes effect at the next edge. `meas_valid` cannot assert in that cycle.

## Test plan
- **Mode 00 train:** square wave toggling every 16 cycles (period 32, high 16), `en` = 1 → first `meas_valid` at the 2nd rise with `period` = 32, `high_time` = 16, `mode_out` = 00. `mode_locked` rises at the 4th rise (3rd measurement).
- **Rate change:** mode 01 (period 64) locked, then switch to period 128 → first 128 measurement gives `mode_out` = 10 and `mode_locked` = 0. Relock after 2 more periods.
- **Tolerance edges:** periods 30, 34 → 00. Periods 29, 35 → 11, never locked. Period 66 → 01.
- **Loss of signal:** locked on period 32, then hold `pulse_in` low → `timeout` is a single pulse 1001 cycles (TIMEOUT + 1) after the last rise, with `mode_locked` = 0 in the same cycle. Period/mode hold, state returns to ARM, and the next two rises give a fresh measurement.
- **Reset and enable mid-measurement:** assert `rst` 10 cycles into a period → all outputs at reset values; the first measurement comes only after two rises post-reset. Repeat using `en` = 0 for 5 cycles → same restart behaviour, with outputs retained.
- **Duty cycle:** period 64 with high 10 → `high_time` = 10, `period` = 64, `mode_out` = 01.
